pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 16: width of all cycle counters and measurement outputs.
REQ-002 Parameter TIMEOUT, default 2**CNT_W-1: cycles without an expected edge before a measurement is abandoned.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 pwm_in  input  1  PWM waveform under measurement, asynchronous to clk.
REQ-006 period  output  CNT_W  clk cycles between the last two rising edges of pwm_in.
REQ-007 high_time  output  CNT_W  clk cycles pwm_in was high within that period.
REQ-008 meas_valid  output  1  one-cycle pulse when period/high_time update.
REQ-009 timeout  output  1  sticky flag: no edge seen within TIMEOUT cycles (0 % or 100 % duty, or input lost).
REQ-010 level  output  1  synchronized pwm_in level; meaningful when timeout=1.

Function
REQ-011 pwm_in SHALL pass a 2-flop synchronizer; a rise/fall SHALL be flagged for one cycle, 3 cycles after the input transition (fixed latency).
REQ-012 FSM states SHALL be IDLE, HIGH and LOW.
REQ-013 IDLE: wait for a rise, ignoring falls; on rise go to HIGH with cnt<=1.
REQ-014 Every cycle not a rise-in-IDLE/LOW, cnt SHALL increment by 1, saturating at TIMEOUT.
REQ-015 HIGH: on fall, hi_cnt<=cnt and go to LOW.
REQ-016 LOW: on rise, period<=cnt, high_time<=hi_cnt, meas_valid<=1 next cycle, timeout<=0, cnt<=1, go to HIGH.
REQ-017 Consequence: input with rises N cycles apart and high M cycles SHALL report period=N, high_time=M exactly.
REQ-018 In HIGH or LOW, cnt reaching TIMEOUT SHALL set timeout<=1 and return to IDLE; period/high_time SHALL hold previous values; meas_valid SHALL NOT pulse.
REQ-019 The first rise after reset or timeout SHALL NOT produce a measurement; the first meas_valid follows the second rise.
REQ-020 Rise and fall cannot coincide after synchronization; a 1-cycle glitch SHALL be measured as a normal pulse (high_time=1), not filtered.
REQ-021 meas_valid SHALL never be high on two consecutive cycles.

Reset
REQ-022 While rst_n=0: state=IDLE, cnt=0, hi_cnt=0, period=0, high_time=0, meas_valid=0, timeout=0, synchronizer flops=0, level=0.
REQ-023 Reset assertion mid-measurement SHALL discard the partial measurement immediately; deassertion SHALL restart at REQ-013.

Structure
REQ-024 Shared package pwm_pkg SHALL hold the FSM state enum and default CNT_W constant, reusable by the PWM generator.
REQ-025 Synchronizer plus edge detect SHALL be one sub-module, sync_edge (ports clk, rst_n, d, q, rise, fall).
REQ-026 No other sub-modules; no multipliers or dividers (duty ratio computed by software).

Verification
REQ-027 Period 100, high 30 repeated 3x -> after second rise meas_valid pulses with period=100, high_time=30; one pulse per period thereafter.
REQ-028 Steady 100 then switch to period 40, high 5 -> next measurement period=40, high_time=5, no intermediate corrupt value.
REQ-029 pwm_in held 1 with TIMEOUT=255 -> timeout=1 within 255 cycles of last rise, level=1, outputs hold; resume 50/20 -> timeout clears with first new meas_valid (period=50, high_time=20).
REQ-030 Single-cycle high pulses every 10 cycles -> period=10, high_time=1.
REQ-031 rst_n low mid-LOW phase -> outputs zero immediately; first meas_valid only after two further rises.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and the default counter width,
// also intended for use by the PWM generator.
package pwm_pkg;

    localparam int PWM_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with registered rise/fall strobes.
// A transition on d shows up as a one-cycle rise/fall pulse three cycles later.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_fall <= ~r_sync & r_prev;
        end
    end

    // q follows r_prev so the level changes in the same cycle as its strobe
    assign q    = r_prev;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with sticky timeout for stuck or lost input.
//   state   | meaning
//   IDLE    | waiting for the first rise after reset or timeout
//   HIGH    | input high, counting since the last rise
//   LOW     | input low, next rise closes the measurement
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int          CNT_W   = PWM_CNT_W,
    parameter int unsigned TIMEOUT = (2**CNT_W) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             level
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    pwm_state_e       r_state;
    pwm_state_e       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_meas_valid;
    logic             r_timeout;

    logic w_level;
    logic w_rise;
    logic w_fall;
    logic w_at_tmo;
    logic w_cnt_load;
    logic w_hi_cap;
    logic w_meas;
    logic w_tmo;

    sync_edge u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pwm_in),
        .q     (w_level),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    assign w_at_tmo = (r_cnt == TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // An edge always wins over a timeout seen in the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_rise) w_next = ST_HIGH;
            ST_HIGH: begin
                if (w_fall)        w_next = ST_LOW;
                else if (w_at_tmo) w_next = ST_IDLE;
            end
            ST_LOW: begin
                if (w_rise)        w_next = ST_HIGH;
                else if (w_at_tmo) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_load = 1'b0;
        w_hi_cap   = 1'b0;
        w_meas     = 1'b0;
        w_tmo      = 1'b0;
        case (r_state)
            ST_IDLE: w_cnt_load = w_rise;
            ST_HIGH: begin
                w_hi_cap = w_fall;
                w_tmo    = ~w_fall & w_at_tmo;
            end
            ST_LOW: begin
                w_cnt_load = w_rise;
                w_meas     = w_rise;
                w_tmo      = ~w_rise & w_at_tmo;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_hi_cnt     <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_cnt_load)    r_cnt <= CNT_W'(1);
            else if (!w_at_tmo) r_cnt <= r_cnt + CNT_W'(1);

            if (w_hi_cap) r_hi_cnt <= r_cnt;

            r_meas_valid <= w_meas;
            if (w_meas) begin
                r_period    <= r_cnt;
                r_high_time <= r_hi_cnt;
                r_timeout   <= 1'b0;
            end else if (w_tmo) begin
                r_timeout   <= 1'b1;
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign meas_valid = r_meas_valid;
    assign timeout    = r_timeout;
    assign level      = w_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives PWM segments, predicts each
// measurement from the drive widths and compares on every meas_valid.
module tb_pwm_capture;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 255;

    typedef struct packed {
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] hi;
    } meas_t;

    logic             clk;
    logic             rst_n;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;
    logic             level;

    meas_t sb[$];
    int    n_pass;
    int    n_total;
    logic  prev_mv;
    logic  m_armed;
    int    m_since;
    int    m_hi;
    int    tmo_at;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock; compare any measurement the DUT presents against the scoreboard.
    task automatic step();
        meas_t e;
        @(posedge clk);
        #1;
        if (meas_valid === 1'b1) begin
            check("mv_back_to_back", 32'(prev_mv), 32'd0);
            check("timeout_clear_on_meas", 32'(timeout), 32'd0);
            check("meas_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("period", 32'(period), 32'(e.per));
                check("high_time", 32'(high_time), 32'(e.hi));
            end
        end
        prev_mv = meas_valid;
    endtask

    // Hold pwm_in at lvl for n cycles; a 0->1 transition closes the model's period.
    task automatic drive(input logic lvl, input int n);
        meas_t e;
        if (lvl && !pwm_in) begin
            if (m_armed) begin
                e.per = CNT_W'(m_since);
                e.hi  = CNT_W'(m_hi);
                sb.push_back(e);
            end
            m_armed = 1'b1;
            m_since = 0;
        end else if (!lvl && pwm_in) begin
            m_hi = m_since;
        end
        pwm_in = lvl;
        for (int i = 0; i < n; i++) begin
            step();
            m_since++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        prev_mv = 1'b0;
        m_armed = 1'b0;
        m_since = 0;
        m_hi    = 0;
        rst_n   = 1'b0;
        pwm_in  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_period", 32'(period), 32'd0);
        check("rst_high_time", 32'(high_time), 32'd0);
        check("rst_meas_valid", 32'(meas_valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        rst_n = 1'b1;

        // 100/30 steady
        drive(1'b0, 10);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 30);
            drive(1'b0, 70);
        end
        check("sb_drained_100_30", 32'(sb.size()), 32'd0);

        // switch to 40/5
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5);
            drive(1'b0, 35);
        end
        check("sb_drained_40_5", 32'(sb.size()), 32'd0);

        // single-cycle pulses every 10
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1);
            drive(1'b0, 9);
        end
        check("sb_drained_10_1", 32'(sb.size()), 32'd0);

        // stuck high: timeout after 3 sync + 1 load + TIMEOUT count cycles
        tmo_at = -1;
        for (int i = 1; i <= 300; i++) begin
            drive(1'b1, 1);
            if (timeout === 1'b1 && tmo_at < 0) tmo_at = i;
        end
        m_armed = 1'b0;
        check("timeout_latency", 32'(tmo_at), 32'(3 + 1 + TIMEOUT));
        check("timeout_sticky", 32'(timeout), 32'd1);
        check("timeout_level", 32'(level), 32'd1);
        check("timeout_hold_period", 32'(period), 32'd10);
        check("timeout_hold_high", 32'(high_time), 32'd1);
        check("sb_drained_tmo", 32'(sb.size()), 32'd0);

        // resume 50/20: first rise only re-arms
        drive(1'b0, 30);
        drive(1'b1, 20);
        drive(1'b0, 30);
        check("timeout_still_set", 32'(timeout), 32'd1);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 20);
            drive(1'b0, 30);
        end
        check("timeout_cleared", 32'(timeout), 32'd0);
        check("sb_drained_50_20", 32'(sb.size()), 32'd0);

        // reset in the middle of a LOW phase
        drive(1'b1, 20);
        drive(1'b0, 10);
        rst_n = 1'b0;
        #1;
        check("midrst_period", 32'(period), 32'd0);
        check("midrst_high_time", 32'(high_time), 32'd0);
        check("midrst_meas_valid", 32'(meas_valid), 32'd0);
        check("midrst_timeout", 32'(timeout), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("sb_drained_midrst", 32'(sb.size()), 32'd0);
        m_armed = 1'b0;
        drive(1'b0, 3);
        rst_n = 1'b1;
        drive(1'b0, 5);
        drive(1'b1, 20);
        drive(1'b0, 30);
        check("post_rst_no_meas", 32'(period), 32'd0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 20);
            drive(1'b0, 30);
        end
        check("post_rst_period", 32'(period), 32'd50);
        check("sb_drained_final", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
